// File: rtl/mo_pixel_serializer.sv
// rtl/mo_pixel_serializer.sv - motion-object tile serializer driving MOSR/LMPD_b
// Double-buffered: a holding register feeds an 8-pixel shifter so consecutive tiles stream without gaps.
module mo_pixel_serializer #(
  parameter int         COLOR_W     = 3,
  parameter logic [3:0] TRANSP_CODE = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  input  logic [COLOR_W-1:0] ld_color,
  input  logic               ld_hflip,
  input  logic               ld_last,
  output logic [COLOR_W+3:0] MOSR,
  output logic               LMPD_b,
  output logic               busy,
  output logic               obj_done,
  output logic               underrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_e;

  state_e state_q, state_d;

  logic               hold_full_q, hold_full_d;
  logic [31:0]        hold_data_q, hold_data_d;
  logic [COLOR_W-1:0] hold_color_q, hold_color_d;
  logic               hold_hflip_q, hold_hflip_d;
  logic               hold_last_q, hold_last_d;

  logic [31:0]        sh_data_q, sh_data_d;
  logic [COLOR_W-1:0] sh_color_q, sh_color_d;
  logic               sh_hflip_q, sh_hflip_d;
  logic               sh_last_q, sh_last_d;
  logic [2:0]         idx_q, idx_d;

  logic [COLOR_W+3:0] mosr_q, mosr_d;
  logic               lmpd_b_q, lmpd_b_d;
  logic               obj_done_q, obj_done_d;
  logic               underrun_q, underrun_d;

  logic               transfer;
  logic [2:0]         bit_sel;
  logic [7:0]         p0, p1, p2, p3;
  logic [3:0]         cur_pix;

  // Plane bit for the current emission slot; hflip walks the tile LSB first.
  always_comb begin
    bit_sel = sh_hflip_q ? idx_q : (3'd7 - idx_q);
    p3      = sh_data_q[31:24];
    p2      = sh_data_q[23:16];
    p1      = sh_data_q[15:8];
    p0      = sh_data_q[7:0];
    cur_pix = {p3[bit_sel], p2[bit_sel], p1[bit_sel], p0[bit_sel]};
  end

  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_color_d = hold_color_q;
    hold_hflip_d = hold_hflip_q;
    hold_last_d  = hold_last_q;
    sh_data_d    = sh_data_q;
    sh_color_d   = sh_color_q;
    sh_hflip_d   = sh_hflip_q;
    sh_last_d    = sh_last_q;
    idx_d        = idx_q;
    mosr_d       = mosr_q;
    lmpd_b_d     = 1'b1;
    obj_done_d   = 1'b0;
    underrun_d   = underrun_q;
    transfer     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_en) mosr_d = {{COLOR_W{1'b0}}, TRANSP_CODE};
        if (hold_full_q) begin
          transfer = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (pix_en) begin
          mosr_d   = {sh_color_q, cur_pix};
          lmpd_b_d = (cur_pix == TRANSP_CODE);
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            obj_done_d = sh_last_q;
            if (hold_full_q) begin
              transfer = 1'b1;
            end else if (sh_last_q) begin
              state_d = IDLE;
            end else begin
              state_d    = STALL;
              underrun_d = 1'b1;
            end
          end
        end
      end
      STALL: begin
        if (pix_en) mosr_d = {sh_color_q, TRANSP_CODE};
        if (hold_full_q) begin
          transfer = 1'b1;
          state_d  = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transfer and load are mutually exclusive: transfer needs a full hold, load an empty one.
    if (transfer) begin
      sh_data_d   = hold_data_q;
      sh_color_d  = hold_color_q;
      sh_hflip_d  = hold_hflip_q;
      sh_last_d   = hold_last_q;
      idx_d       = 3'd0;
      hold_full_d = 1'b0;
    end else if (ld_valid && !hold_full_q) begin
      hold_data_d  = ld_data;
      hold_color_d = ld_color;
      hold_hflip_d = ld_hflip;
      hold_last_d  = ld_last;
      hold_full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_color_q <= '0;
      hold_hflip_q <= 1'b0;
      hold_last_q  <= 1'b0;
      sh_data_q    <= '0;
      sh_color_q   <= '0;
      sh_hflip_q   <= 1'b0;
      sh_last_q    <= 1'b0;
      idx_q        <= 3'd0;
      mosr_q       <= {{COLOR_W{1'b0}}, TRANSP_CODE};
      lmpd_b_q     <= 1'b1;
      obj_done_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_color_q <= hold_color_d;
      hold_hflip_q <= hold_hflip_d;
      hold_last_q  <= hold_last_d;
      sh_data_q    <= sh_data_d;
      sh_color_q   <= sh_color_d;
      sh_hflip_q   <= sh_hflip_d;
      sh_last_q    <= sh_last_d;
      idx_q        <= idx_d;
      mosr_q       <= mosr_d;
      lmpd_b_q     <= lmpd_b_d;
      obj_done_q   <= obj_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ld_ready = ~hold_full_q;
  assign MOSR     = mosr_q;
  assign LMPD_b   = lmpd_b_q;
  assign busy     = (state_q != IDLE);
  assign obj_done = obj_done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_mo_pixel_serializer.sv
// tb/tb_mo_pixel_serializer.sv - self-checking bench for mo_pixel_serializer
module tb_mo_pixel_serializer;

  logic        clk;
  logic        reset;
  logic        pix_en;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic [2:0]  ld_color;
  logic        ld_hflip;
  logic        ld_last;
  logic [6:0]  MOSR;
  logic        LMPD_b;
  logic        busy;
  logic        obj_done;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  mo_pixel_serializer #(.COLOR_W(3), .TRANSP_CODE(4'hF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_color (ld_color),
    .ld_hflip (ld_hflip),
    .ld_last  (ld_last),
    .MOSR     (MOSR),
    .LMPD_b   (LMPD_b),
    .busy     (busy),
    .obj_done (obj_done),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference pixel: emission slot i of a tile, bit = hflip ? i : 7-i, planes P3..P0.
  function automatic logic [3:0] ref_pix(input logic [31:0] d, input logic hf, input int i);
    int b;
    b = hf ? i : 7 - i;
    return {d[24 + b], d[16 + b], d[8 + b], d[b]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] d, input logic [2:0] c, input logic hf, input logic lst);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_color = c;
    ld_hflip = hf;
    ld_last  = lst;
  endtask

  task automatic wait_busy(input string tag);
    for (int k = 0; k < 10 && !busy; k++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_busy: busy=%b required 1 within 10 clocks", tag, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (MOSR !== 7'h0F || LMPD_b !== 1'b1 || ld_ready !== 1'b1 || busy !== 1'b0 ||
        obj_done !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: MOSR=%h LMPD_b=%b ld_ready=%b busy=%b obj_done=%b underrun=%b required 0f 1 1 0 0 0",
               MOSR, LMPD_b, ld_ready, busy, obj_done, underrun);
    end
    // Get mid-SHIFT with a second tile waiting in the holding register.
    present($urandom, 3'($urandom), 1'b0, 1'b0);
    tick();
    ld_valid = 1'b0;
    wait_busy("reset");
    present($urandom, 3'($urandom), 1'b0, 1'b1);
    tick();
    ld_valid = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pix_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (MOSR !== 7'h0F || LMPD_b !== 1'b1 || ld_ready !== 1'b1 || busy !== 1'b0 ||
        obj_done !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: MOSR=%h LMPD_b=%b ld_ready=%b busy=%b obj_done=%b underrun=%b required 0f 1 1 0 0 0",
               MOSR, LMPD_b, ld_ready, busy, obj_done, underrun);
    end
    // Both buffers discarded: idle pixels stay transparent and nothing starts shifting.
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (MOSR !== 7'h0F || LMPD_b !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_pix[%0d]: MOSR=%h LMPD_b=%b busy=%b required 0f 1 0", i, MOSR, LMPD_b, busy);
      end
    end
    pix_en = 1'b0;
    tick();
  endtask

  task automatic test_single(input logic hf);
    logic [31:0] d;
    logic [6:0]  e;
    d = 32'hFFFF_FF7F;
    present(d, 3'd5, hf, 1'b1);
    tick();
    ld_valid = 1'b0;
    wait_busy("single");
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = {3'd5, ref_pix(d, hf, i)};
      n_checks++;
      if (MOSR !== e || LMPD_b !== (e[3:0] == 4'hF) || obj_done !== (i == 7)) begin
        n_fail++;
        $display("FAIL single_hf%0d_pix[%0d]: MOSR=%h LMPD_b=%b obj_done=%b required %h %b %b",
                 hf, i, MOSR, LMPD_b, obj_done, e, (e[3:0] == 4'hF), (i == 7));
      end
    end
    pix_en = 1'b0;
    tick();
    n_checks++;
    if (obj_done !== 1'b0 || LMPD_b !== 1'b1 || busy !== 1'b0 || MOSR !== e) begin
      n_fail++;
      $display("FAIL single_hf%0d_after: obj_done=%b LMPD_b=%b busy=%b MOSR=%h required 0 1 0 %h",
               hf, obj_done, LMPD_b, busy, MOSR, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] td[4];
    logic [2:0]  tc[4];
    logic        th[4];
    logic [6:0]  exp_q[$];
    logic [6:0]  e;
    int          nt, nxt, np;
    nt = $urandom_range(2, 4);
    for (int t = 0; t < nt; t++) begin
      td[t] = $urandom;
      if ($urandom_range(0, 1) == 1) td[t] = td[t] | 32'hFF00_0000;
      tc[t] = 3'($urandom);
      th[t] = 1'($urandom);
      for (int i = 0; i < 8; i++) exp_q.push_back({tc[t], ref_pix(td[t], th[t], i)});
    end
    present(td[0], tc[0], th[0], nt == 1);
    tick();
    ld_valid = 1'b0;
    wait_busy("b2b");
    nxt = 1;
    np  = 8 * nt;
    pix_en = 1'b1;
    for (int p = 0; p < np; p++) begin
      if (nxt < nt && ld_ready) begin
        present(td[nxt], tc[nxt], th[nxt], nxt == nt - 1);
        nxt++;
      end
      tick();
      ld_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (MOSR !== e || LMPD_b !== (e[3:0] == 4'hF) || obj_done !== (p == np - 1) || underrun !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_pix[%0d]: MOSR=%h LMPD_b=%b obj_done=%b underrun=%b required %h %b %b 0",
                 p, MOSR, LMPD_b, obj_done, underrun, e, (e[3:0] == 4'hF), (p == np - 1));
      end
    end
    pix_en = 1'b0;
    n_checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0 || nxt != nt) begin
      n_fail++;
      $display("FAIL b2b_end: ld_ready=%b busy=%b tiles_loaded=%0d required 1 0 %0d", ld_ready, busy, nxt, nt);
    end
    tick();
  endtask

  task automatic test_half_rate;
    logic [31:0] d;
    logic [2:0]  c;
    logic        hf;
    logic [6:0]  e;
    d  = $urandom & 32'hF0F0_FFFF;
    c  = 3'($urandom);
    hf = 1'($urandom);
    present(d, c, hf, 1'b1);
    tick();
    ld_valid = 1'b0;
    wait_busy("half");
    for (int i = 0; i < 8; i++) begin
      pix_en = 1'b1;
      tick();
      e = {c, ref_pix(d, hf, i)};
      n_checks++;
      if (MOSR !== e || LMPD_b !== (e[3:0] == 4'hF)) begin
        n_fail++;
        $display("FAIL half_pix[%0d]: MOSR=%h LMPD_b=%b required %h %b", i, MOSR, LMPD_b, e, (e[3:0] == 4'hF));
      end
      pix_en = 1'b0;
      tick();
      n_checks++;
      if (MOSR !== e || LMPD_b !== 1'b1) begin
        n_fail++;
        $display("FAIL half_gap[%0d]: MOSR=%h LMPD_b=%b required %h 1", i, MOSR, LMPD_b, e);
      end
    end
  endtask

  task automatic test_underrun;
    logic [31:0] da, db;
    logic [2:0]  ca, cb;
    logic        ha, hb;
    logic [6:0]  e;
    da = $urandom; ca = 3'($urandom); ha = 1'($urandom);
    db = $urandom; cb = 3'($urandom); hb = 1'($urandom);
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_pre: underrun=%b required 0", underrun);
    end
    present(da, ca, ha, 1'b0);
    tick();
    ld_valid = 1'b0;
    wait_busy("underrun");
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = {ca, ref_pix(da, ha, i)};
      n_checks++;
      if (MOSR !== e || LMPD_b !== (e[3:0] == 4'hF) || obj_done !== 1'b0) begin
        n_fail++;
        $display("FAIL underrun_a_pix[%0d]: MOSR=%h LMPD_b=%b obj_done=%b required %h %b 0",
                 i, MOSR, LMPD_b, obj_done, e, (e[3:0] == 4'hF));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (MOSR !== {ca, 4'hF} || LMPD_b !== 1'b1 || underrun !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL underrun_stall[%0d]: MOSR=%h LMPD_b=%b underrun=%b busy=%b required %h 1 1 1",
                 i, MOSR, LMPD_b, underrun, busy, {ca, 4'hF});
      end
    end
    pix_en = 1'b0;
    present(db, cb, hb, 1'b1);
    tick();
    ld_valid = 1'b0;
    tick();
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = {cb, ref_pix(db, hb, i)};
      n_checks++;
      if (MOSR !== e || LMPD_b !== (e[3:0] == 4'hF) || obj_done !== (i == 7) || underrun !== 1'b1) begin
        n_fail++;
        $display("FAIL underrun_b_pix[%0d]: MOSR=%h LMPD_b=%b obj_done=%b underrun=%b required %h %b %b 1",
                 i, MOSR, LMPD_b, obj_done, underrun, e, (e[3:0] == 4'hF), (i == 7));
      end
    end
    pix_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: underrun=%b required 0 after reset", underrun);
    end
  endtask

  initial begin
    reset    = 1'b1;
    pix_en   = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_color = '0;
    ld_hflip = 1'b0;
    ld_last  = 1'b0;
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    for (int r = 0; r < 4; r++) test_back_to_back();
    test_half_rate();
    test_underrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
